// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue slice: datapath sizing, opcodes and
// the issue FSM state encoding.
package alu_issue_pkg;

  localparam int DW   = 8;
  localparam int NREG = 8;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SHL = 3'b101;
  localparam logic [2:0] ALU_SHR = 3'b110;
  localparam logic [2:0] ALU_CMP = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

endpackage

// File: rtl/alu_issue_reg_file.sv
// Register file for alu_issue: NREG x DW storage, two combinational operand
// read ports, one combinational debug port and one synchronous write port.
module reg_file #(
  parameter int DW   = alu_issue_pkg::DW,
  parameter int NREG = alu_issue_pkg::NREG,
  localparam int AW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] ra_addr,
  output logic [DW-1:0] ra_data,
  input  logic [AW-1:0] rb_addr,
  output logic [DW-1:0] rb_data,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd
);
  import alu_issue_pkg::*;

  logic [DW-1:0] r_mem [NREG];

  // Reset must clear every entry, so storage is flops rather than block RAM.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        r_mem[i] <= '0;
      end
    end else if (we) begin
      r_mem[wa] <= wd;
    end
  end

  assign ra_data  = r_mem[ra_addr];
  assign rb_data  = r_mem[rb_addr];
  assign dbg_data = r_mem[dbg_addr];

endmodule

// File: rtl/alu_issue.sv
// Four-state issue stage: latches one instruction, reads operands, drives an
// external combinational ALU and writes the result back one cycle later.
module alu_issue #(
  parameter int DW   = alu_issue_pkg::DW,
  parameter int NREG = alu_issue_pkg::NREG,
  localparam int AW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_op,
  input  logic [AW-1:0] in_rd,
  input  logic [AW-1:0] in_rs,
  input  logic          in_imm_en,
  input  logic [DW-1:0] in_imm,
  output logic [2:0]    alu_op,
  output logic [DW-1:0] r0,
  output logic [DW-1:0] r1,
  input  logic [DW-1:0] alu_result,
  input  logic          alu_done,
  output logic          retire_valid,
  output logic [AW-1:0] retire_rd,
  output logic [DW-1:0] retire_data,
  output logic          zero_flag,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);
  import alu_issue_pkg::*;

  state_t        r_state;
  logic [AW-1:0] r_rs;
  logic          r_imm_en;
  logic [DW-1:0] r_imm;
  logic [DW-1:0] w_rd_data;
  logic [DW-1:0] w_rs_data;
  logic          w_we;

  assign in_ready = (r_state == IDLE);
  assign w_we     = (r_state == WB);

  reg_file #(.DW(DW), .NREG(NREG)) u_reg_file (
    .clk      (clk),
    .reset    (reset),
    .ra_addr  (retire_rd),
    .ra_data  (w_rd_data),
    .rb_addr  (r_rs),
    .rb_data  (w_rs_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .we       (w_we),
    .wa       (retire_rd),
    .wd       (retire_data)
  );

  // retire_rd doubles as the latched destination, so it is valid from READ on.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_rs         <= '0;
      r_imm_en     <= 1'b0;
      r_imm        <= '0;
      alu_op       <= '0;
      r0           <= '0;
      r1           <= '0;
      retire_valid <= 1'b0;
      retire_rd    <= '0;
      retire_data  <= '0;
      zero_flag    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_state   <= READ;
            alu_op    <= in_op;
            retire_rd <= in_rd;
            r_rs      <= in_rs;
            r_imm_en  <= in_imm_en;
            r_imm     <= in_imm;
          end
        end
        READ: begin
          r0      <= w_rd_data;
          r1      <= r_imm_en ? r_imm : w_rs_data;
          r_state <= EXEC;
        end
        EXEC: begin
          retire_data  <= alu_result;
          zero_flag    <= alu_done;
          retire_valid <= 1'b1;
          r_state      <= WB;
        end
        WB: begin
          retire_valid <= 1'b0;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a behavioural ALU attached to its ports;
// expected results are hand-computed constants.
module tb_alu_issue;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_op;
  logic [2:0] in_rd;
  logic [2:0] in_rs;
  logic       in_imm_en;
  logic [7:0] in_imm;
  logic [2:0] alu_op;
  logic [7:0] r0;
  logic [7:0] r1;
  logic [7:0] alu_result;
  logic       alu_done;
  logic       retire_valid;
  logic [2:0] retire_rd;
  logic [7:0] retire_data;
  logic       zero_flag;
  logic [2:0] dbg_addr;
  logic [7:0] dbg_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_issue dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_op        (in_op),
    .in_rd        (in_rd),
    .in_rs        (in_rs),
    .in_imm_en    (in_imm_en),
    .in_imm       (in_imm),
    .alu_op       (alu_op),
    .r0           (r0),
    .r1           (r1),
    .alu_result   (alu_result),
    .alu_done     (alu_done),
    .retire_valid (retire_valid),
    .retire_rd    (retire_rd),
    .retire_data  (retire_data),
    .zero_flag    (zero_flag),
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg_data)
  );

  // External ALU; cmp yields 1 when the operands are equal.
  always_comb begin
    alu_result = 8'h00;
    case (alu_op)
      3'b000: alu_result = r0 + r1;
      3'b001: alu_result = r0 - r1;
      3'b010: alu_result = r0 & r1;
      3'b011: alu_result = r0 | r1;
      3'b100: alu_result = r0 ^ r1;
      3'b101: alu_result = r0 << r1[2:0];
      3'b110: alu_result = r0 >> r1[2:0];
      default: alu_result = (r0 == r1) ? 8'h01 : 8'h00;
    endcase
    alu_done = (alu_result == 8'h00);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic read_reg(input string tag, input logic [2:0] addr, input logic [7:0] exp);
    dbg_addr = addr;
    #1;
    check_val(tag, {24'd0, dbg_data}, {24'd0, exp});
  endtask

  // One full instruction; inputs are scrambled after transfer to prove latching.
  task automatic exec_instr(input string tag, input logic [2:0] op, input logic [2:0] rd,
                            input logic [2:0] rs, input logic ie, input logic [7:0] imm,
                            input logic [7:0] exp_d, input logic exp_z);
    @(negedge clk);
    check_val({tag, ".ready_idle"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; in_op = op; in_rd = rd; in_rs = rs; in_imm_en = ie; in_imm = imm;
    @(posedge clk); #1;
    in_valid = 1'b0; in_op = ~op; in_rd = rd + 3'd1; in_rs = ~rs; in_imm_en = ~ie; in_imm = ~imm;
    check_val({tag, ".ready_read"}, {31'd0, in_ready}, 32'd0);
    check_val({tag, ".alu_op_read"}, {29'd0, alu_op}, {29'd0, op});
    @(posedge clk); #1;
    check_val({tag, ".rv_exec"}, {31'd0, retire_valid}, 32'd0);
    @(posedge clk); #1;
    check_val({tag, ".rv_wb"}, {31'd0, retire_valid}, 32'd1);
    check_val({tag, ".retire_rd"}, {29'd0, retire_rd}, {29'd0, rd});
    check_val({tag, ".retire_data"}, {24'd0, retire_data}, {24'd0, exp_d});
    check_val({tag, ".zero_flag"}, {31'd0, zero_flag}, {31'd0, exp_z});
    check_val({tag, ".ready_wb"}, {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    check_val({tag, ".rv_idle"}, {31'd0, retire_valid}, 32'd0);
    read_reg({tag, ".reg"}, rd, exp_d);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_op = '0; in_rd = '0; in_rs = '0;
    in_imm_en = 1'b0; in_imm = '0; dbg_addr = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 8; i++) read_reg($sformatf("reset.R%0d", i), 3'(i), 8'h00);
    check_val("reset.in_ready", {31'd0, in_ready}, 32'd1);
    check_val("reset.zero_flag", {31'd0, zero_flag}, 32'd0);
    check_val("reset.retire_valid", {31'd0, retire_valid}, 32'd0);

    exec_instr("add_r1_5", 3'b000, 3'd1, 3'd0, 1'b1, 8'd5, 8'd5, 1'b0);
    exec_instr("add_r1_3", 3'b000, 3'd1, 3'd0, 1'b1, 8'd3, 8'd8, 1'b0);
    exec_instr("add_r2_7", 3'b000, 3'd2, 3'd0, 1'b1, 8'd7, 8'd7, 1'b0);
    exec_instr("sub_r2_r2", 3'b001, 3'd2, 3'd2, 1'b0, 8'h00, 8'h00, 1'b1);

    exec_instr("add_r6_3", 3'b000, 3'd6, 3'd0, 1'b1, 8'd3, 8'd3, 1'b0);
    exec_instr("add_r6_r6", 3'b000, 3'd6, 3'd6, 1'b0, 8'h00, 8'd6, 1'b0);
    exec_instr("xor_r6", 3'b100, 3'd6, 3'd0, 1'b1, 8'h0F, 8'h09, 1'b0);
    exec_instr("shl_r6", 3'b101, 3'd6, 3'd0, 1'b1, 8'd1, 8'h12, 1'b0);
    exec_instr("shr_r6", 3'b110, 3'd6, 3'd0, 1'b1, 8'd2, 8'h04, 1'b0);
    exec_instr("or_r6", 3'b011, 3'd6, 3'd0, 1'b1, 8'h30, 8'h34, 1'b0);
    exec_instr("and_r6", 3'b010, 3'd6, 3'd0, 1'b1, 8'h0C, 8'h04, 1'b0);
    exec_instr("sub_r6", 3'b001, 3'd6, 3'd0, 1'b1, 8'h05, 8'hFF, 1'b0);
    exec_instr("add_r7_r6", 3'b000, 3'd7, 3'd6, 1'b0, 8'h00, 8'hFF, 1'b0);
    read_reg("r1_final", 3'd1, 8'd8);

    // Back-to-back: in_valid held high accepts on edges 0 and 4 only.
    @(negedge clk);
    in_valid = 1'b1; in_op = 3'b000; in_rd = 3'd5; in_rs = 3'd0; in_imm_en = 1'b1; in_imm = 8'd1;
    for (int i = 0; i < 8; i++) begin
      check_val($sformatf("stream.ready%0d", i), {31'd0, in_ready}, (i % 4 == 0) ? 32'd1 : 32'd0);
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    read_reg("stream.r5", 3'd5, 8'd2);

    // Reset during EXEC aborts the instruction.
    @(negedge clk);
    in_valid = 1'b1; in_op = 3'b000; in_rd = 3'd3; in_rs = 3'd0; in_imm_en = 1'b1; in_imm = 8'd9;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_val("abort.rv0", {31'd0, retire_valid}, 32'd0);
    check_val("abort.ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_val($sformatf("abort.rv%0d", i + 1), {31'd0, retire_valid}, 32'd0);
    end
    read_reg("abort.r3", 3'd3, 8'h00);
    read_reg("abort.r1_cleared", 3'd1, 8'h00);

    exec_instr("add_r4_ff", 3'b000, 3'd4, 3'd0, 1'b1, 8'hFF, 8'hFF, 1'b0);
    exec_instr("add_r4_wrap", 3'b000, 3'd4, 3'd0, 1'b1, 8'h01, 8'h00, 1'b1);
    exec_instr("cmp_r4_0", 3'b111, 3'd4, 3'd0, 1'b1, 8'h00, 8'h01, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001: Parameters SHALL be: DW, default 8, datapath width; NREG, default 8, register count (3-bit register addresses).
REQ-002: clk  input  1  single clock; all state updates on rising edge.
REQ-003: reset  input  1  synchronous, active-high reset.
REQ-004: in_valid  input  1  instruction offered.
REQ-005: in_ready  output  1  block accepts instruction; transfer when in_valid and in_ready are both high at a rising edge.
REQ-006: in_op  input  3  ALU opcode: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 shl, 110 shr, 111 cmp.
REQ-007: in_rd  input  3  destination and first-source register.
REQ-008: in_rs  input  3  second-source register.
REQ-009: in_imm_en  input  1  select in_imm instead of R[in_rs] as second operand.
REQ-010: in_imm  input  8  immediate operand.
REQ-011: alu_op  output  3  opcode driven to the downstream ALU.
REQ-012: r0, r1  output  8 each  operands driven to the ALU.
REQ-013: alu_result  input  8  combinational ALU result.
REQ-014: alu_done  input  1  ALU zero indication (result == 0).
REQ-015: retire_valid  output  1  one-cycle pulse marking writeback.
REQ-016: retire_rd  output  3  register written at retire.
REQ-017: retire_data  output  8  value written at retire.
REQ-018: zero_flag  output  1  registered alu_done from the last retired instruction.
REQ-019: dbg_addr  input  3  debug register-read address.
REQ-020: dbg_data  output  8  combinational R[dbg_addr].

Function
REQ-021: The FSM SHALL have states IDLE, READ, EXEC, WB, advancing IDLE->READ on transfer, then READ->EXEC->WB->IDLE unconditionally, one cycle each.
REQ-022: in_ready SHALL be 1 only in IDLE; in_valid while not in IDLE is ignored.
REQ-023: On transfer, in_op, in_rd, in_rs, in_imm_en and in_imm SHALL be latched; later input changes have no effect.
REQ-024: At the READ->EXEC edge, r0 SHALL load R[rd] and r1 SHALL load in_imm if imm_en was set, else R[rs]; alu_op SHALL present the latched opcode from READ onward.
REQ-025: r0, r1 and alu_op SHALL remain stable from EXEC through WB.
REQ-026: At the EXEC->WB edge, alu_result SHALL be captured into retire_data and alu_done into zero_flag.
REQ-027: In WB, retire_valid SHALL be 1 and retire_rd the latched rd; at the WB->IDLE edge R[rd] SHALL be written with retire_data.
REQ-028: Latency: transfer at edge k gives retire_valid high during the cycle after edge k+2; register write takes effect at edge k+3; peak throughput one instruction per 4 cycles.
REQ-029: rd == rs SHALL read the same pre-write value for both operands.
REQ-030: An instruction accepted in the IDLE cycle immediately after WB SHALL see the value written by the prior instruction.
REQ-031: cmp (111) SHALL write its 0/1 result to R[rd] like any other opcode.
REQ-032: All arithmetic SHALL be DW-bit, with wrap-around supplied by the ALU; no carry is stored.
REQ-033: dbg_data SHALL reflect a write on the cycle after the writing edge.

Reset
REQ-034: While reset is high at an edge, the FSM SHALL go to IDLE and all registers R[0..7], r0, r1, alu_op, retire_data, retire_rd and zero_flag SHALL clear to 0; retire_valid SHALL be 0.
REQ-035: Reset in READ, EXEC or WB SHALL abort the instruction with no register write and no retire pulse; in_ready SHALL be 1 on the cycle after reset deasserts.

Structure
REQ-036: A shared package SHALL hold the opcode constants (ALU_ADD..ALU_CMP), the state enum (IDLE, READ, EXEC, WB), and DW and NREG.
REQ-037: The register file SHALL be a sub-module, reg_file, with NREGxDW storage, two combinational read ports plus the debug port, and one synchronous write port.
REQ-038: The ALU SHALL remain external; alu_issue only drives and samples its ports.

Verification
REQ-039: After reset: dbg reads of all 8 registers -> 0; in_ready = 1; zero_flag = 0.
REQ-040: add R1, imm 5, then add R1, imm 3 -> retire_data 5 then 8; R1 = 8; zero_flag 0; retire 3 cycles after each transfer.
REQ-041: R2 = 7 via imm, then sub R2, rs=R2 -> retire_data 0; zero_flag 1; R2 = 0.
REQ-042: in_valid held high continuously -> one acceptance every 4 cycles; in_ready low in READ, EXEC and WB.
REQ-043: Reset asserted during EXEC of add R3, imm 9 -> R3 stays 0; no retire_valid pulse.
REQ-044: R4 = 0xFF, then add R4, imm 1 -> R4 = 0x00, zero_flag 1; cmp R4, imm 0 -> R4 = 1, zero_flag 0.
